comparator_serial: RTL and testbench

COMPARATOR_SERIAL -- requirements
Module: comparator_serial

---
 rtl/comparator_serial.sv | 111 +++++++++++
 tb/tb_comparator_serial.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/comparator_serial.sv
// Bit-serial unsigned magnitude comparator: scans A and B MSB-first, one bit per cycle.
// Latency: result registered at the edge that leaves DONE, DATA_WIDTH+1 edges after accept; single-pair handshake (o_ready only in IDLE).
module comparator_serial #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_valid,
    output logic                  o_gt,
    output logic                  o_lt,
    output logic                  o_eq,
    output logic                  o_busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] sh_a;
    logic [DATA_WIDTH-1:0] sh_b;
    logic                  decided;
    logic                  gt;
    logic                  lt;
    logic                  msb_a;
    logic                  msb_b;

    assign msb_a   = sh_a[DATA_WIDTH-1];
    assign msb_b   = sh_b[DATA_WIDTH-1];
    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_valid) next_state = COMPARE;
            COMPARE: if (cnt == LAST_BIT) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt     <= '0;
            sh_a    <= '0;
            sh_b    <= '0;
            decided <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            o_valid <= 1'b0;
            o_gt    <= 1'b0;
            o_lt    <= 1'b0;
            o_eq    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        sh_a    <= i_a;
                        sh_b    <= i_b;
                        cnt     <= '0;
                        decided <= 1'b0;
                        gt      <= 1'b0;
                        lt      <= 1'b0;
                    end
                end
                COMPARE: begin
                    // The first differing bit from the top decides; lower bits cannot override it.
                    if (!decided && (msb_a != msb_b)) begin
                        gt      <= msb_a & ~msb_b;
                        lt      <= ~msb_a & msb_b;
                        decided <= 1'b1;
                    end
                    sh_a <= {sh_a[DATA_WIDTH-2:0], 1'b0};
                    sh_b <= {sh_b[DATA_WIDTH-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                end
                DONE: begin
                    o_valid <= 1'b1;
                    o_gt    <= gt;
                    o_lt    <= lt;
                    o_eq    <= ~decided;
                end
                default: begin
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_serial.sv
// Scoreboard bench for comparator_serial: expected results queued at accept, popped by a negedge monitor.
module tb_comparator_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vld = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic         rdy, res_vld, gt, lt, eq, busy;

    always #5 clk = ~clk;

    comparator_serial #(.DATA_WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (vld),
        .o_ready (rdy),
        .i_a     (a),
        .i_b     (b),
        .o_valid (res_vld),
        .o_gt    (gt),
        .o_lt    (lt),
        .o_eq    (eq),
        .o_busy  (busy)
    );

    typedef struct {
        logic [2:0] r;
        int         e;
    } exp_t;

    exp_t       q[$];
    int         n_vec     = 0;
    int         n_miss    = 0;
    int         edge_cnt  = 0;
    int         rst_epoch = 0;
    int         my_epoch  = 0;
    int         n_acc     = 0;
    int         n_abort   = 0;
    int         n_res     = 0;
    bit         started   = 1'b0;
    bit         have      = 1'b0;
    logic [2:0] last_r    = '0;

    // Reference: plain unsigned compare, encoded {gt, lt, eq}.
    function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x > y) return 3'b100;
        if (x < y) return 3'b010;
        return 3'b001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accept tracking: sees the same pre-edge values the DUT samples.
    always @(posedge clk) begin
        if (rst) begin
            n_abort += q.size();
            q.delete();
            rst_epoch++;
        end else if (vld === 1'b1 && rdy === 1'b1) begin
            q.push_back('{r: ref_cmp(a, b), e: edge_cnt});
            n_acc++;
        end
        edge_cnt++;
    end

    always @(negedge clk) begin
        if (started) begin
            if (rst_epoch != my_epoch) begin
                my_epoch = rst_epoch;
                have     = 1'b0;
            end
            if (res_vld !== 1'b0) begin
                n_res++;
                if (q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL spurious_valid: o_valid=%b with no pending accept (t=%0t)", res_vld, $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result_gt_lt_eq", {29'd0, gt, lt, eq}, {29'd0, e.r});
                    chk("latency_edges", edge_cnt - 1 - e.e, W + 1);
                    last_r = e.r;
                    have   = 1'b1;
                end
            end else if (have) begin
                chk("hold_result", {29'd0, gt, lt, eq}, {29'd0, last_r});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, res_vld, 0);
        chk({tag, "_gt"},    gt,      0);
        chk({tag, "_lt"},    lt,      0);
        chk({tag, "_eq"},    eq,      0);
        chk({tag, "_busy"},  busy,    0);
        chk({tag, "_ready"}, rdy,     1);
    endtask

    // Waits for o_ready, offering random junk meanwhile, then presents one pair for one edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        int t = 0;
        while (rdy !== 1'b1 && t < 100) begin
            vld = 1'($urandom_range(0, 1));
            a   = W'($urandom);
            b   = W'($urandom);
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_vec++;
            n_miss++;
            $display("FAIL ready_timeout: o_ready=%b after %0d cycles, expected 1", rdy, t);
        end
        vld = 1'b1;
        a   = x;
        b   = y;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || res_vld === 1'b1) && t < 4 * W) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4 * W) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x, y;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");
        started = 1'b1;

        send(8'hA5, 8'h5A);
        chk("busy_in_compare",  busy, 1);
        chk("ready_in_compare", rdy,  0);
        drain();
        send(8'h00, 8'hFF);
        drain();
        send(8'h3C, 8'h3C);
        drain();
        send(8'h81, 8'h80);
        drain();
        send(8'hFF, 8'h00);
        drain();

        // New data held valid while busy must be ignored.
        send(8'h12, 8'h34);
        for (int i = 0; i <= W; i++) begin
            chk("ready_low_while_busy", rdy, 0);
            vld = 1'b1;
            a   = W'($urandom);
            b   = W'($urandom);
            @(negedge clk);
        end
        send(8'h99, 8'h98);
        drain();

        // Reset on the 4th COMPARE cycle aborts the pair.
        send(8'hF0, 8'h0F);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("abort");
        repeat (W + 4) @(negedge clk);
        chk("abort_no_result", n_res, n_acc - n_abort);
        send(8'h7E, 8'h7F);
        drain();

        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 7))
                0: begin x = W'($urandom); y = x;          end
                1: begin x = '0;           y = '1;         end
                2: begin x = '1;           y = W'($urandom); end
                3: begin x = W'($urandom); y = x ^ W'(1);  end
                default: begin x = W'($urandom); y = W'($urandom); end
            endcase
            send(x, y);
        end
        drain();

        chk("one_valid_per_accept", n_res, n_acc - n_abort);
        chk("scoreboard_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
